// File: rtl/write_buffer_if.sv
// Cache/memory port bundle for the posted-write buffer.
// slave is the buffer's view; master is the side that drives the cache requests and models memory.
interface write_buffer_if #(
    parameter int BA = 28,
    parameter int BW = 128
);
    logic          wb_read_i;
    logic          wb_wr_i;
    logic [BA-1:0] wb_addr_i;
    logic [BW-1:0] wb_wr_data_i;
    logic          wb_busywait_o;
    logic [BW-1:0] wb_read_data_o;
    logic          wb_m_read_o;
    logic          wb_m_wr_o;
    logic [BA-1:0] wb_m_addr_o;
    logic [BW-1:0] wb_m_write_data_o;
    logic          wb_m_busywait_i;
    logic [BW-1:0] wb_m_read_data_i;
    logic          wb_empty_o;

    modport slave (
        input  wb_read_i, wb_wr_i, wb_addr_i, wb_wr_data_i, wb_m_busywait_i, wb_m_read_data_i,
        output wb_busywait_o, wb_read_data_o, wb_m_read_o, wb_m_wr_o, wb_m_addr_o,
               wb_m_write_data_o, wb_empty_o
    );

    modport master (
        output wb_read_i, wb_wr_i, wb_addr_i, wb_wr_data_i, wb_m_busywait_i, wb_m_read_data_i,
        input  wb_busywait_o, wb_read_data_o, wb_m_read_o, wb_m_wr_o, wb_m_addr_o,
               wb_m_write_data_o, wb_empty_o
    );
endinterface

// File: rtl/write_buffer.sv
// Posted-write buffer between the cache and data memory: one-cycle write-back acceptance,
// FIFO drain, read forwarding from buffered blocks, and read misses ahead of queued drains.
module write_buffer #(
    parameter int LINE_SIZE  = 32,
    parameter int BLOCK_SIZE = 2,
    parameter int ADDR_SIZE  = 32,
    parameter int DEPTH      = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    write_buffer_if.slave bus
);
    localparam int BA = ADDR_SIZE - BLOCK_SIZE - 2;
    localparam int BW = (2 ** BLOCK_SIZE) * LINE_SIZE;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

    state_t                     state_q;
    logic [DEPTH-1:0]           valid_q;
    logic [DEPTH-1:0][BA-1:0]   addr_q;
    logic [DEPTH-1:0][BW-1:0]   data_q;
    logic [PW-1:0]              head_q, tail_q;
    logic [CW-1:0]              count_q, count_nxt;
    logic                       done_q, started_q;
    logic                       m_read_q, m_wr_q, empty_q;
    logic [BA-1:0]              m_addr_q;
    logic [BW-1:0]              m_wdata_q, rd_data_q;

    logic          rd_req, wr_req, head_busy, full;
    logic          rd_hit, wr_hit, rd_miss, wr_alloc, wr_merge, pop, rd_done;
    logic [PW-1:0] rd_idx, wr_idx, idx;

    // A simultaneous read and write is served as a read.
    assign rd_req = bus.wb_read_i & ~done_q;
    assign wr_req = bus.wb_wr_i & ~bus.wb_read_i & ~done_q;
    assign full   = (count_q == CW'(DEPTH));

    // The head is in flight while draining, and also in IDLE with entries queued, because
    // the drain launches on that same edge from the head's pre-edge data.
    assign head_busy = (state_q == DRAIN) | ((state_q == IDLE) & (count_q != '0));

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        rd_hit = 1'b0;
        rd_idx = '0;
        wr_hit = 1'b0;
        wr_idx = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (valid_q[idx] && addr_q[idx] == bus.wb_addr_i) begin
                rd_hit = 1'b1;
                rd_idx = idx;
                if (!(k == 0 && head_busy)) begin
                    wr_hit = 1'b1;
                    wr_idx = idx;
                end
            end
        end
    end

    assign rd_miss  = rd_req & ~rd_hit;
    assign wr_merge = wr_req & wr_hit;
    assign wr_alloc = wr_req & ~wr_hit & ~full;
    assign pop      = (state_q == DRAIN) & started_q & ~bus.wb_m_busywait_i;
    assign rd_done  = (state_q == READ) & started_q & ~bus.wb_m_busywait_i;

    always_comb begin
        count_nxt = count_q;
        case ({wr_alloc, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            started_q <= 1'b0;
            m_read_q  <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
        end else begin
            done_q <= wr_merge | wr_alloc | (rd_req & rd_hit) | rd_done;
            if (rd_done)
                rd_data_q <= bus.wb_m_read_data_i;
            else if (rd_req && rd_hit)
                rd_data_q <= data_q[rd_idx];

            if (pop)      valid_q[head_q] <= 1'b0;
            if (wr_alloc) valid_q[tail_q] <= 1'b1;
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(wr_alloc);
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);

            case (state_q)
                IDLE: begin
                    started_q <= 1'b0;
                    if (rd_miss) begin
                        state_q  <= READ;
                        m_read_q <= 1'b1;
                        m_addr_q <= bus.wb_addr_i;
                    end else if (count_q != '0) begin
                        state_q   <= DRAIN;
                        m_wr_q    <= 1'b1;
                        m_addr_q  <= addr_q[head_q];
                        m_wdata_q <= data_q[head_q];
                    end
                end
                DRAIN: begin
                    started_q <= 1'b1;
                    if (pop) begin
                        state_q   <= IDLE;
                        m_wr_q    <= 1'b0;
                        started_q <= 1'b0;
                    end
                end
                READ: begin
                    started_q <= 1'b1;
                    if (rd_done) begin
                        state_q   <= IDLE;
                        m_read_q  <= 1'b0;
                        started_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entry storage needs no reset; valid_q qualifies every use.
    always_ff @(posedge clk_i) begin
        if (wr_alloc) begin
            addr_q[tail_q] <= bus.wb_addr_i;
            data_q[tail_q] <= bus.wb_wr_data_i;
        end else if (wr_merge) begin
            data_q[wr_idx] <= bus.wb_wr_data_i;
        end
    end

    assign bus.wb_busywait_o     = (bus.wb_read_i | bus.wb_wr_i) & ~done_q;
    assign bus.wb_read_data_o    = rd_data_q;
    assign bus.wb_m_read_o       = m_read_q;
    assign bus.wb_m_wr_o         = m_wr_q;
    assign bus.wb_m_addr_o       = m_addr_q;
    assign bus.wb_m_write_data_o = m_wdata_q;
    assign bus.wb_empty_o        = empty_q;
endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: memory busy is driven by hand, memory read data is
// a fixed function of the address, and memory request launches are logged in order.
module tb_write_buffer;
    localparam int BA = 28;
    localparam int BW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_busy = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   lat;

    always #5 clk = ~clk;

    write_buffer_if #(.BA(BA), .BW(BW)) bus();
    assign bus.wb_m_busywait_i  = mem_busy;
    assign bus.wb_m_read_data_i = {4{4'hC, bus.wb_m_addr_o}};

    write_buffer #(.LINE_SIZE(32), .BLOCK_SIZE(2), .ADDR_SIZE(32), .DEPTH(4)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    // memory request log: kind 0 = write, 1 = read, captured on each request rise
    bit              ev_kind[$];
    logic [BA-1:0]   ev_addr[$];
    logic [BW-1:0]   ev_data[$];
    logic            prev_wr = 1'b0;
    logic            prev_rd = 1'b0;

    always @(negedge clk) begin
        if (bus.wb_m_wr_o && !prev_wr) begin
            ev_kind.push_back(1'b0);
            ev_addr.push_back(bus.wb_m_addr_o);
            ev_data.push_back(bus.wb_m_write_data_o);
        end
        if (bus.wb_m_read_o && !prev_rd) begin
            ev_kind.push_back(1'b1);
            ev_addr.push_back(bus.wb_m_addr_o);
            ev_data.push_back('0);
        end
        prev_wr <= bus.wb_m_wr_o;
        prev_rd <= bus.wb_m_read_o;
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rdat(input logic [BA-1:0] a);
        return {4{4'hC, a}};
    endfunction

    task automatic do_write(input logic [BA-1:0] a, input logic [BW-1:0] d, output int l);
        bus.wb_addr_i    = a;
        bus.wb_wr_data_i = d;
        bus.wb_wr_i      = 1'b1;
        l = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.wb_busywait_o) break;
            l++;
        end
        @(posedge clk);
        #1 bus.wb_wr_i = 1'b0;
    endtask

    task automatic do_read(input logic [BA-1:0] a, output int l);
        bus.wb_addr_i = a;
        bus.wb_read_i = 1'b1;
        l = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.wb_busywait_o) break;
            l++;
        end
        @(posedge clk);
        #1 bus.wb_read_i = 1'b0;
    endtask

    task automatic wait_mwr(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.wb_m_wr_o) break;
        end
        chk(tag, bus.wb_m_wr_o, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.wb_empty_o && !bus.wb_m_wr_o && !bus.wb_m_read_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input string tag, input bit kind, input logic [BA-1:0] a,
                             input logic [BW-1:0] d, input bit use_d);
        chk({tag, "_present"}, (ev_kind.size() > 0), 1'b1);
        if (ev_kind.size() > 0) begin
            chk({tag, "_kind"}, ev_kind.pop_front(), kind);
            chk({tag, "_addr"}, ev_addr.pop_front(), a);
            if (use_d) chk({tag, "_data"}, ev_data.pop_front(), d);
            else void'(ev_data.pop_front());
        end
    endtask

    initial begin
        bus.wb_read_i    = 1'b0;
        bus.wb_wr_i      = 1'b0;
        bus.wb_addr_i    = '0;
        bus.wb_wr_data_i = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_empty", bus.wb_empty_o, 1'b1);
        chk("rst_mwr", bus.wb_m_wr_o, 1'b0);
        chk("rst_mrd", bus.wb_m_read_o, 1'b0);
        chk("rst_maddr", bus.wb_m_addr_o, '0);
        chk("rst_mwdata", bus.wb_m_write_data_o, '0);
        chk("rst_rdata", bus.wb_read_data_o, '0);
        chk("rst_busy", bus.wb_busywait_o, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // single write drains to memory
        do_write(28'h19, {4{32'hAAAA_AAAA}}, lat);
        chk("a_wr_lat", lat, 1);
        wait_drained("a_drain_to");
        chk("a_empty", bus.wb_empty_o, 1'b1);
        expect_ev("a_ev0", 1'b0, 28'h19, {4{32'hAAAA_AAAA}}, 1'b1);

        // coalescing behind a stalled drain
        mem_busy = 1'b1;
        do_write(28'h05, {4{32'h5555_5555}}, lat);
        chk("b_wr0_lat", lat, 1);
        wait_mwr("b_mwr_start");
        do_write(28'h19, {4{32'h1111_1111}}, lat);
        chk("b_wr1_lat", lat, 1);
        do_write(28'h19, {4{32'h2222_2222}}, lat);
        chk("b_wr2_lat", lat, 1);
        mem_busy = 1'b0;
        wait_drained("b_drain_to");
        expect_ev("b_ev0", 1'b0, 28'h05, {4{32'h5555_5555}}, 1'b1);
        expect_ev("b_ev1", 1'b0, 28'h19, {4{32'h2222_2222}}, 1'b1);
        chk("b_ev_count", ev_kind.size(), 0);

        // fill the buffer; fifth write waits for a pop, then takes one more cycle
        mem_busy = 1'b1;
        do_write(28'h10, {4{32'h1000_0010}}, lat);
        wait_mwr("c_mwr_start");
        for (int i = 1; i < 4; i++) begin
            do_write(28'h10 + 28'(i), {4{32'h1000_0010 + 32'(i)}}, lat);
            chk("c_wr_lat", lat, 1);
        end
        bus.wb_addr_i    = 28'h14;
        bus.wb_wr_data_i = {4{32'h1000_0014}};
        bus.wb_wr_i      = 1'b1;
        repeat (5) @(negedge clk);
        chk("c_full_busy", bus.wb_busywait_o, 1'b1);
        @(posedge clk);
        #1 mem_busy = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.wb_busywait_o) break;
            lat++;
        end
        chk("c_full_release_lat", lat, 2);
        @(posedge clk);
        #1 bus.wb_wr_i = 1'b0;
        wait_drained("c_drain_to");
        for (int i = 0; i < 5; i++)
            expect_ev("c_ev", 1'b0, 28'h10 + 28'(i), {4{32'h1000_0010 + 32'(i)}}, 1'b1);

        // read hit forwarded from the buffer
        mem_busy = 1'b1;
        do_write(28'h22, {4{32'hBEEF_0022}}, lat);
        do_read(28'h22, lat);
        chk("d_rd_lat", lat, 1);
        chk("d_rd_data", bus.wb_read_data_o, {4{32'hBEEF_0022}});
        mem_busy = 1'b0;
        wait_drained("d_drain_to");
        expect_ev("d_ev0", 1'b0, 28'h22, {4{32'hBEEF_0022}}, 1'b1);
        chk("d_no_mread", ev_kind.size(), 0);

        // read miss waits for the in-flight drain, then goes ahead of the queued one
        mem_busy = 1'b1;
        do_write(28'h40, {4{32'h4040_4040}}, lat);
        wait_mwr("e_mwr_start");
        do_write(28'h41, {4{32'h4141_4141}}, lat);
        fork
            do_read(28'h30, lat);
            begin
                repeat (4) @(posedge clk);
                #1 mem_busy = 1'b0;
            end
        join
        chk("e_rd_data", bus.wb_read_data_o, rdat(28'h30));
        wait_drained("e_drain_to");
        expect_ev("e_ev0", 1'b0, 28'h40, {4{32'h4040_4040}}, 1'b1);
        expect_ev("e_ev1", 1'b1, 28'h30, '0, 1'b0);
        expect_ev("e_ev2", 1'b0, 28'h41, {4{32'h4141_4141}}, 1'b1);

        // reset in the middle of a drain
        mem_busy = 1'b1;
        do_write(28'h50, {4{32'h5050_5050}}, lat);
        wait_mwr("f_mwr_start");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("f_rst_mwr", bus.wb_m_wr_o, 1'b0);
        chk("f_rst_empty", bus.wb_empty_o, 1'b1);
        chk("f_rst_rdata", bus.wb_read_data_o, '0);
        #1 rst = 1'b0;
        mem_busy = 1'b0;
        @(posedge clk);
        #1;
        do_read(28'h50, lat);
        chk("f_rd_lat", lat, 3);
        chk("f_rd_data", bus.wb_read_data_o, rdat(28'h50));
        expect_ev("f_ev0", 1'b0, 28'h50, {4{32'h5050_5050}}, 1'b1);
        expect_ev("f_ev1", 1'b1, 28'h50, '0, 1'b0);
        wait_drained("f_idle_to");
        chk("f_ev_count", ev_kind.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
